// File: rtl/retire_trace_packer_pkg.sv
// retire_trace_packer_pkg: shared record, counter-select and state encodings for the trace packer
package retire_trace_packer_pkg;
  typedef enum logic [1:0] {REC_REG = 2'd0, REC_LOAD = 2'd1, REC_STORE = 2'd2, REC_HALT = 2'd3} rec_type_e;
  typedef struct packed {
    rec_type_e   typ;
    logic [15:0] a;
    logic [15:0] b;
  } rec_t;
  localparam logic [2:0] SEL_CYC  = 3'd0;
  localparam logic [2:0] SEL_INST = 3'd1;
  localparam logic [2:0] SEL_IREQ = 3'd2;
  localparam logic [2:0] SEL_IHIT = 3'd3;
  localparam logic [2:0] SEL_DREQ = 3'd4;
  localparam logic [2:0] SEL_DHIT = 3'd5;
  localparam logic [2:0] SEL_DROP = 3'd6;
  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE} state_e;
endpackage

// File: rtl/retire_trace_packer_fifo.sv
// trace_fifo_mw: DEPTH x record FIFO with an atomic 0..4-entry write port and a single read port
module trace_fifo_mw
  import retire_trace_packer_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [2:0]               wr_n,
  input  rec_t [3:0]               wr_rec,
  input  logic                     rd_en,
  output rec_t                     rd_rec,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   free
);
  localparam int AW = $clog2(DEPTH);
  rec_t mem [DEPTH];
  logic [AW:0] wp_q, wp_d, rp_q, rp_d;
  assign wp_d = wp_q + (AW+1)'(wr_n);
  assign rp_d = rp_q + (AW+1)'(rd_en);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (i < int'(wr_n)) mem[AW'(wp_q + (AW+1)'(i))] <= wr_rec[i];
  end
  assign rd_rec = mem[rp_q[AW-1:0]];
  assign empty  = wp_q == rp_q;
  // Full (MSBs differ, low bits equal) shows up as free == 0
  assign free   = (AW+1)'(DEPTH) - (wp_q - rp_q);
endmodule

// File: rtl/retire_trace_packer.sv
// retire_trace_packer: packs per-cycle retire events into trace records, streams them out, keeps perf counters
module retire_trace_packer
  import retire_trace_packer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [15:0]   pc,
  input  logic          reg_write,
  input  logic [2:0]    wr_reg,
  input  logic [15:0]   wr_data,
  input  logic          mem_read,
  input  logic          mem_write,
  input  logic [15:0]   mem_addr,
  input  logic [15:0]   mem_data_in,
  input  logic [15:0]   mem_data_out,
  input  logic          halt,
  input  logic          icache_req,
  input  logic          icache_hit,
  input  logic          dcache_req,
  input  logic          dcache_hit,
  output logic          trc_valid,
  input  logic          trc_ready,
  output logic [1:0]    trc_type,
  output logic [15:0]   trc_a,
  output logic [15:0]   trc_b,
  input  logic [2:0]    cnt_sel,
  output logic [CW-1:0] cnt_val,
  output logic          overflow,
  output logic          done
);
  localparam int AW = $clog2(DEPTH);
  state_e st_q, st_d;
  rec_t [3:0] cand, recs;
  logic [3:0] inc;
  logic [2:0] n;
  logic [AW:0] free;
  logic empty, run, fits, pop;
  rec_t head;
  logic [CW-1:0] cyc_q, inst_q, ireq_q, ihit_q, dreq_q, dhit_q, drop_q;
  logic ovf_q;
  assign run = st_q == ST_RUN;
  always_comb begin
    cand[0] = '{REC_REG, {13'b0, wr_reg}, wr_data};
    cand[1] = '{REC_LOAD, mem_addr, mem_data_out};
    cand[2] = '{REC_STORE, mem_addr, mem_data_in};
    cand[3] = '{REC_HALT, pc, inst_q[15:0] + 16'd1};
    inc = run ? {halt, mem_write, mem_read, reg_write} : 4'b0;
    recs = '0;
    n = '0;
    for (int i = 0; i < 4; i++)
      if (inc[i]) begin
        recs[n[1:0]] = cand[i];
        n = n + 3'd1;
      end
  end
  // Free slots come from registered occupancy, so a same-cycle pop never helps the push
  assign fits = (AW+1)'(n) <= free;
  trace_fifo_mw #(.DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_n   (fits ? n : 3'd0),
    .wr_rec (recs),
    .rd_en  (pop),
    .rd_rec (head),
    .empty  (empty),
    .free   (free)
  );
  assign trc_valid = !empty && st_q != ST_DONE;
  assign pop       = trc_valid && trc_ready;
  assign trc_type  = trc_valid ? head.typ : 2'b0;
  assign trc_a     = trc_valid ? head.a : 16'b0;
  assign trc_b     = trc_valid ? head.b : 16'b0;
  always_comb begin
    st_d = st_q;
    if (run && halt) st_d = ST_DRAIN;
    if (st_q == ST_DRAIN && ((pop && head.typ == REC_HALT) || empty)) st_d = ST_DONE;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q   <= ST_RUN;
      cyc_q  <= '0;
      inst_q <= '0;
      ireq_q <= '0;
      ihit_q <= '0;
      dreq_q <= '0;
      dhit_q <= '0;
      drop_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      st_q <= st_d;
      if (run) begin
        cyc_q  <= cyc_q + CW'(1);
        inst_q <= inst_q + CW'(halt | reg_write | mem_write);
        ireq_q <= ireq_q + CW'(icache_req);
        ihit_q <= ihit_q + CW'(icache_hit);
        dreq_q <= dreq_q + CW'(dcache_req);
        dhit_q <= dhit_q + CW'(dcache_hit);
        if (!fits) drop_q <= drop_q + CW'(n);
        if (!fits) ovf_q <= 1'b1;
      end
    end
  end
  always_comb begin
    case (cnt_sel)
      SEL_CYC:  cnt_val = cyc_q;
      SEL_INST: cnt_val = inst_q;
      SEL_IREQ: cnt_val = ireq_q;
      SEL_IHIT: cnt_val = ihit_q;
      SEL_DREQ: cnt_val = dreq_q;
      SEL_DHIT: cnt_val = dhit_q;
      SEL_DROP: cnt_val = drop_q;
      default:  cnt_val = '0;
    endcase
  end
  assign overflow = ovf_q;
  assign done     = st_q == ST_DONE;
endmodule

// File: tb/tb_retire_trace_packer.sv
// tb_retire_trace_packer: directed checks of the trace packer, with a DEPTH=4 copy for overflow behaviour
module tb_retire_trace_packer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [15:0] pc, wr_data, mem_addr, mem_data_in, mem_data_out;
  logic [2:0] wr_reg, cnt_sel;
  logic reg_write, mem_read, mem_write, halt, trc_ready;
  logic icache_req, icache_hit, dcache_req, dcache_hit;
  logic trc_valid, overflow, done, s_valid, s_overflow, s_done;
  logic [1:0] trc_type, s_type;
  logic [15:0] trc_a, trc_b, s_a, s_b;
  logic [31:0] cnt_val, s_cnt_val;
  int n_chk = 0;
  int n_fail = 0;
  int idx;
  logic [33:0] bp_exp [6];
  always #5 clk = ~clk;
  retire_trace_packer u_dut (
    .clk(clk), .rst(rst), .pc(pc), .reg_write(reg_write), .wr_reg(wr_reg), .wr_data(wr_data),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .halt(halt), .icache_req(icache_req), .icache_hit(icache_hit),
    .dcache_req(dcache_req), .dcache_hit(dcache_hit), .trc_valid(trc_valid), .trc_ready(trc_ready),
    .trc_type(trc_type), .trc_a(trc_a), .trc_b(trc_b), .cnt_sel(cnt_sel), .cnt_val(cnt_val),
    .overflow(overflow), .done(done)
  );
  retire_trace_packer #(.DEPTH(4)) u_small (
    .clk(clk), .rst(rst), .pc(pc), .reg_write(reg_write), .wr_reg(wr_reg), .wr_data(wr_data),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .halt(halt), .icache_req(icache_req), .icache_hit(icache_hit),
    .dcache_req(dcache_req), .dcache_hit(dcache_hit), .trc_valid(s_valid), .trc_ready(trc_ready),
    .trc_type(s_type), .trc_a(s_a), .trc_b(s_b), .cnt_sel(cnt_sel), .cnt_val(s_cnt_val),
    .overflow(s_overflow), .done(s_done)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic idle();
    reg_write = 0; mem_read = 0; mem_write = 0; halt = 0;
    icache_req = 0; icache_hit = 0; dcache_req = 0; dcache_hit = 0;
    pc = 0; wr_reg = 0; wr_data = 0; mem_addr = 0; mem_data_in = 0; mem_data_out = 0;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic sel_cnt(input logic [2:0] s);
    cnt_sel = s;
    #1;
  endtask
  task automatic do_reset();
    idle();
    trc_ready = 0;
    rst = 0;
    step();
    step();
    rst = 1;
  endtask
  task automatic rec_reg(input logic [2:0] r, input logic [15:0] d);
    reg_write = 1; wr_reg = r; wr_data = d;
  endtask
  initial begin
    idle();
    trc_ready = 0;
    cnt_sel = 0;
    step();
    step();
    chk("rst_valid", trc_valid, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_done", done, 0);
    chk("rst_rec", {trc_type, trc_a, trc_b}, 0);
    chk("rst_cyc", cnt_val, 0);
    rst = 1;
    // single register write
    trc_ready = 1;
    rec_reg(3, 16'h1234);
    step();
    idle();
    chk("t1_valid", trc_valid, 1);
    chk("t1_rec", {trc_type, trc_a, trc_b}, {2'd0, 16'h0003, 16'h1234});
    sel_cnt(1);
    chk("t1_inst", cnt_val, 1);
    step();
    chk("t1_popped", trc_valid, 0);
    // register write plus load in one cycle
    rec_reg(1, 16'hBEEF);
    mem_read = 1; mem_addr = 16'h0040; mem_data_out = 16'hBEEF;
    step();
    idle();
    chk("t2_reg", {trc_valid, trc_type, trc_a, trc_b}, {1'b1, 2'd0, 16'h0001, 16'hBEEF});
    step();
    chk("t2_load", {trc_valid, trc_type, trc_a, trc_b}, {1'b1, 2'd1, 16'h0040, 16'hBEEF});
    step();
    chk("t2_empty", trc_valid, 0);
    sel_cnt(1);
    chk("t2_inst", cnt_val, 2);
    // atomic drop on the DEPTH=4 copy
    do_reset();
    for (int i = 0; i < 3; i++) begin
      rec_reg(3'(i), 16'h0100 + 16'(i));
      step();
    end
    rec_reg(5, 16'h0555);
    mem_write = 1; mem_addr = 16'h0070; mem_data_in = 16'h0777;
    step();
    idle();
    chk("t3_ovf_small", s_overflow, 1);
    chk("t3_ovf_big", overflow, 0);
    sel_cnt(6);
    chk("t3_drop_small", s_cnt_val, 2);
    chk("t3_drop_big", cnt_val, 0);
    rec_reg(7, 16'h7777);
    step();
    idle();
    chk("t3_drop_hold", s_cnt_val, 2);
    sel_cnt(1);
    chk("t3_inst_small", s_cnt_val, 5);
    trc_ready = 1;
    for (int k = 0; k < 4; k++) begin
      chk("t3_drain", {s_valid, s_type, s_a, s_b},
          {1'b1, 2'd0, (k == 3) ? 16'h0007 : 16'(k), (k == 3) ? 16'h7777 : 16'h0100 + 16'(k)});
      step();
    end
    chk("t3_empty", s_valid, 0);
    // cache counters and freeze on halt
    do_reset();
    trc_ready = 1;
    for (int i = 0; i < 10; i++) begin
      icache_req = 1;
      icache_hit = (i < 7);
      step();
    end
    icache_req = 1; icache_hit = 0; halt = 1; pc = 16'h0020;
    step();
    halt = 0; pc = 0;
    chk("t4_halt_rec", {trc_valid, trc_type, trc_a, trc_b}, {1'b1, 2'd3, 16'h0020, 16'h0001});
    sel_cnt(2);
    chk("t4_ireq", cnt_val, 11);
    sel_cnt(3);
    chk("t4_ihit", cnt_val, 7);
    sel_cnt(0);
    chk("t4_cyc", cnt_val, 11);
    step();
    chk("t4_done", done, 1);
    chk("t4_valid_done", trc_valid, 0);
    icache_hit = 1;
    repeat (5) step();
    sel_cnt(2);
    chk("t4_ireq_frozen", cnt_val, 11);
    sel_cnt(0);
    chk("t4_cyc_frozen", cnt_val, 11);
    chk("t4_done_hold", done, 1);
    idle();
    // backpressure over six queued records
    do_reset();
    bp_exp[0] = {2'd0, 16'h0001, 16'h1111};
    bp_exp[1] = {2'd0, 16'h0002, 16'h2222};
    bp_exp[2] = {2'd1, 16'h0050, 16'h2222};
    bp_exp[3] = {2'd2, 16'h0060, 16'h3333};
    bp_exp[4] = {2'd0, 16'h0004, 16'h4444};
    bp_exp[5] = {2'd3, 16'h0030, 16'h0005};
    rec_reg(1, 16'h1111); step(); idle();
    rec_reg(2, 16'h2222); mem_read = 1; mem_addr = 16'h0050; mem_data_out = 16'h2222; step(); idle();
    mem_write = 1; mem_addr = 16'h0060; mem_data_in = 16'h3333; step(); idle();
    rec_reg(4, 16'h4444); step(); idle();
    halt = 1; pc = 16'h0030; step(); idle();
    idx = 0;
    for (int c = 0; c < 24 && idx < 6; c++) begin
      chk("bp_valid", trc_valid, 1);
      chk("bp_rec", {trc_type, trc_a, trc_b}, bp_exp[idx]);
      chk("bp_not_done", done, 0);
      trc_ready = (c % 2 == 1);
      step();
      if (trc_ready) idx++;
    end
    chk("bp_count", idx, 6);
    chk("bp_done", done, 1);
    chk("bp_valid_done", trc_valid, 0);
    // asynchronous reset while draining
    do_reset();
    rec_reg(1, 16'h000A); step();
    rec_reg(2, 16'h000B); step(); idle();
    halt = 1; pc = 16'h0040; step(); idle();
    chk("t6_queued", trc_valid, 1);
    #3;
    rst = 0;
    #1;
    chk("t6_async_valid", trc_valid, 0);
    chk("t6_async_done", done, 0);
    sel_cnt(0);
    chk("t6_cyc_zero", cnt_val, 0);
    sel_cnt(1);
    chk("t6_inst_zero", cnt_val, 0);
    step();
    chk("t6_hold_valid", trc_valid, 0);
    rst = 1;
    trc_ready = 1;
    rec_reg(5, 16'h5555);
    step();
    idle();
    chk("t6_run_rec", {trc_valid, trc_type, trc_a, trc_b}, {1'b1, 2'd0, 16'h0005, 16'h5555});
    chk("t6_run_inst", cnt_val, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
